// File: rtl/flappy_pkg.sv
// Shared types and field-geometry defaults for the flappy game blocks
// (field, pipe generator, score event generator).
package flappy_pkg;

    localparam int DEF_ROWS     = 16;
    localparam int DEF_COLS     = 16;
    localparam int DEF_BIRD_COL = 2;

    localparam int ROW_W = $clog2(DEF_ROWS);
    localparam int COL_W = $clog2(DEF_COLS);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        IN_PIPE,
        GAMEOVER,
        WIN
    } state_t;

endpackage

// File: rtl/score_event_gen_if.sv
// Field-side bundle for the score event generator: bird/pipe/gap positions in,
// score pulse and game status out.
interface score_event_gen_if
    import flappy_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) ();

    logic                      start;
    logic [$clog2(ROWS)-1:0]   bird_row;
    logic [$clog2(COLS)-1:0]   pipe_col;
    logic [$clog2(ROWS)-1:0]   gap_top;
    logic [$clog2(ROWS)-1:0]   gap_bot;
    logic                      score_inc;
    logic                      game_over;
    logic                      win;
    logic                      running;
    logic [9:0]                pass_count;

    modport master (
        output start, bird_row, pipe_col, gap_top, gap_bot,
        input  score_inc, game_over, win, running, pass_count
    );

    modport slave (
        input  start, bird_row, pipe_col, gap_top, gap_bot,
        output score_inc, game_over, win, running, pass_count
    );

endinterface

// File: rtl/score_event_gen_gap_check.sv
// Combinational test of whether the bird sits inside the pipe gap and
// off the ground row. An inverted gap (top below bottom) means no opening.
module gap_check
    import flappy_pkg::*;
#(
    parameter int ROWS = DEF_ROWS
) (
    input  logic [$clog2(ROWS)-1:0] bird_row,
    input  logic [$clog2(ROWS)-1:0] gap_top,
    input  logic [$clog2(ROWS)-1:0] gap_bot,
    output logic                    safe
);

    localparam int RW = $clog2(ROWS);
    localparam logic [RW-1:0] GROUND = RW'(ROWS - 1);

    assign safe = (gap_top <= gap_bot)
               && (bird_row >= gap_top)
               && (bird_row <= gap_bot)
               && (bird_row != GROUND);

endmodule

// File: rtl/score_event_gen.sv
// Emits one registered score_inc pulse per pipe the bird clears, and freezes
// scoring on a collision (game_over) or on reaching MAX_SCORE (win).
module score_event_gen
    import flappy_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int BIRD_COL  = DEF_BIRD_COL,
    parameter int MAX_SCORE = 999
) (
    input  logic              Clock,
    input  logic              RST,
    score_event_gen_if.slave  bus
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] GROUND = RW'(ROWS - 1);
    localparam logic [CW-1:0] BIRD_C = CW'(BIRD_COL);
    localparam logic [9:0]    MAX_C  = 10'(MAX_SCORE);

    state_t     state, next_state;
    logic       safe, at_bird, pass;
    logic       score_inc_q, game_over_q, win_q, running_q;
    logic       score_inc_d, game_over_d, win_d, running_d;
    logic [9:0] pass_count_q, pass_count_d;

    gap_check #(.ROWS(ROWS)) u_gap_check (
        .bird_row (bus.bird_row),
        .gap_top  (bus.gap_top),
        .gap_bot  (bus.gap_bot),
        .safe     (safe)
    );

    assign at_bird = (bus.pipe_col == BIRD_C);
    // Safety only matters while the pipe overlaps the bird; leaving is a pass.
    assign pass    = (state == IN_PIPE) && !at_bird;

    // NOTE: RST is tested first so it overrides a pass detected in the same cycle.
    always_ff @(posedge Clock) begin
        if (RST) begin
            state        <= IDLE;
            score_inc_q  <= 1'b0;
            game_over_q  <= 1'b0;
            win_q        <= 1'b0;
            running_q    <= 1'b0;
            pass_count_q <= '0;
        end else begin
            state        <= next_state;
            score_inc_q  <= score_inc_d;
            game_over_q  <= game_over_d;
            win_q        <= win_d;
            running_q    <= running_d;
            pass_count_q <= pass_count_d;
        end
    end

    // NOTE: next_state is defaulted before the case so no path infers a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (bus.start) next_state = ARMED;
            ARMED: begin
                if (bus.bird_row == GROUND) next_state = GAMEOVER;
                else if (at_bird)           next_state = safe ? IN_PIPE : GAMEOVER;
            end
            IN_PIPE: begin
                if (at_bird) begin
                    if (!safe) next_state = GAMEOVER;
                end else begin
                    next_state = (pass_count_q + 10'd1 == MAX_C) ? WIN : ARMED;
                end
            end
            GAMEOVER: next_state = GAMEOVER;
            WIN:      next_state = WIN;
            default:  next_state = IDLE;
        endcase
    end

    // Outputs are derived from the upcoming state so they register in step with it.
    always_comb begin
        score_inc_d  = pass;
        game_over_d  = (next_state == GAMEOVER);
        win_d        = (next_state == WIN);
        running_d    = (next_state == ARMED) || (next_state == IN_PIPE);
        pass_count_d = pass_count_q;
        if (pass && (pass_count_q < MAX_C)) pass_count_d = pass_count_q + 10'd1;
    end

    assign bus.score_inc  = score_inc_q;
    assign bus.game_over  = game_over_q;
    assign bus.win        = win_q;
    assign bus.running    = running_q;
    assign bus.pass_count = pass_count_q;

endmodule

// File: tb/tb_score_event_gen.sv
// Directed vector bench for score_event_gen with a small MAX_SCORE so the
// win path is reachable in a few pipes.
module tb_score_event_gen;
    import flappy_pkg::*;

    typedef struct {
        logic       rst;
        logic       start;
        logic [3:0] bird;
        logic [3:0] pc;
        logic [3:0] gt;
        logic [3:0] gb;
        logic       inc;
        logic       go;
        logic       win;
        logic       run;
        logic [9:0] cnt;
    } vec_t;

    logic Clock = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs[$];

    always #5 Clock = ~Clock;

    score_event_gen_if #(.ROWS(16), .COLS(16)) bus ();

    score_event_gen #(
        .ROWS(16), .COLS(16), .BIRD_COL(2), .MAX_SCORE(3)
    ) dut (
        .Clock (Clock),
        .RST   (RST),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input int b, input int pc,
                       input int gt, input int gb, input logic inc, input logic go,
                       input logic w, input logic run, input int cnt);
        vec_t v;
        v.rst = r; v.start = s; v.bird = 4'(b); v.pc = 4'(pc);
        v.gt = 4'(gt); v.gb = 4'(gb); v.inc = inc; v.go = go;
        v.win = w; v.run = run; v.cnt = 10'(cnt);
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input int b, input int pc,
                         input int gt, input int gb);
        RST = r; bus.start = s; bus.bird_row = 4'(b); bus.pipe_col = 4'(pc);
        bus.gap_top = 4'(gt); bus.gap_bot = 4'(gb);
        @(posedge Clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic inc, input logic go,
                             input logic w, input logic run, input int cnt);
        check({tag, ".score_inc"},  32'(bus.score_inc),  32'(inc));
        check({tag, ".game_over"},  32'(bus.game_over),  32'(go));
        check({tag, ".win"},        32'(bus.win),        32'(w));
        check({tag, ".running"},    32'(bus.running),    32'(run));
        check({tag, ".pass_count"}, 32'(bus.pass_count), 32'(cnt));
    endtask

    initial begin
        //   rst s bird pc gt gb | inc go win run cnt
        // reset, then idle ignores pipes
        add(1, 0, 7, 10, 5, 9,  0, 0, 0, 0, 0);
        add(1, 0, 7, 10, 5, 9,  0, 0, 0, 0, 0);
        add(0, 0, 7, 10, 5, 9,  0, 0, 0, 0, 0);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 0, 0);
        add(0, 0, 7,  1, 5, 9,  0, 0, 0, 0, 0);
        // clean pass: pipe 4,3,2,2,1
        add(0, 1, 7,  4, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  3, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  1, 5, 9,  1, 0, 0, 1, 1);
        add(0, 0, 7,  0, 5, 9,  0, 0, 0, 1, 1);
        // pipe already at bird column when started is not counted
        add(1, 0, 7,  2, 5, 9,  0, 0, 0, 0, 0);
        add(0, 1, 7,  2, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  1, 5, 9,  0, 0, 0, 1, 0);
        // collision on entry, then frozen; start ignored
        add(1, 0, 7,  5, 5, 9,  0, 0, 0, 0, 0);
        add(0, 1, 7,  5, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 3,  2, 5, 9,  0, 1, 0, 0, 0);
        add(0, 0, 7,  1, 5, 9,  0, 1, 0, 0, 0);
        add(0, 0, 7,  2, 5, 9,  0, 1, 0, 0, 0);
        add(0, 0, 7,  1, 5, 9,  0, 1, 0, 0, 0);
        add(0, 1, 7,  1, 5, 9,  0, 1, 0, 0, 0);
        // bird leaves gap while still inside the pipe
        add(1, 0, 7,  5, 5, 9,  0, 0, 0, 0, 0);
        add(0, 1, 7,  5, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0,12,  2, 5, 9,  0, 1, 0, 0, 0);
        add(0, 0,12,  1, 5, 9,  0, 1, 0, 0, 0);
        // bird leaves gap in the same cycle the pipe leaves: pass; then ground hit in ARMED
        add(1, 0, 7,  5, 5, 9,  0, 0, 0, 0, 0);
        add(0, 1, 7,  5, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0,12,  1, 5, 9,  1, 0, 0, 1, 1);
        add(0, 0,12,  0, 5, 9,  0, 0, 0, 1, 1);
        add(0, 0,15,  5, 5, 9,  0, 1, 0, 0, 1);
        // three passes reach MAX_SCORE=3; a fourth is ignored
        add(1, 0, 7,  5, 5, 9,  0, 0, 0, 0, 0);
        add(0, 1, 7,  5, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 1, 0);
        add(0, 0, 7,  1, 5, 9,  1, 0, 0, 1, 1);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 1, 1);
        add(0, 0, 7,  1, 5, 9,  1, 0, 0, 1, 2);
        add(0, 0, 7,  2, 5, 9,  0, 0, 0, 1, 2);
        add(0, 0, 7,  1, 5, 9,  1, 0, 1, 0, 3);
        add(0, 0, 7,  2, 5, 9,  0, 0, 1, 0, 3);
        add(0, 0, 7,  1, 5, 9,  0, 0, 1, 0, 3);
        // inverted gap means no opening
        add(1, 0, 7,  5, 9, 5,  0, 0, 0, 0, 0);
        add(0, 1, 7,  5, 9, 5,  0, 0, 0, 1, 0);
        add(0, 0, 7,  2, 9, 5,  0, 1, 0, 0, 0);
        // one-row gap exactly at the bird is safe
        add(1, 0, 7,  5, 7, 7,  0, 0, 0, 0, 0);
        add(0, 1, 7,  5, 7, 7,  0, 0, 0, 1, 0);
        add(0, 0, 7,  2, 7, 7,  0, 0, 0, 1, 0);
        add(0, 0, 7,  1, 7, 7,  1, 0, 0, 1, 1);
        // gap reaching the ground: ground row is never safe
        add(1, 0,14,  5,10,15,  0, 0, 0, 0, 0);
        add(0, 1,14,  5,10,15,  0, 0, 0, 1, 0);
        add(0, 0,14,  2,10,15,  0, 0, 0, 1, 0);
        add(0, 0,15,  2,10,15,  0, 1, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, int'(vecs[i].bird), int'(vecs[i].pc),
                  int'(vecs[i].gt), int'(vecs[i].gb));
            check_all($sformatf("v%0d", i), vecs[i].inc, vecs[i].go,
                      vecs[i].win, vecs[i].run, int'(vecs[i].cnt));
        end

        // Reset asserted in the very cycle a pass is detected.
        drive(1, 0, 7, 5, 5, 9);
        drive(0, 1, 7, 5, 5, 9);
        drive(0, 0, 7, 2, 5, 9);
        check_all("pre_rst_pass", 0, 0, 0, 1, 0);
        drive(1, 0, 7, 1, 5, 9);
        check_all("rst_on_pass", 0, 0, 0, 0, 0);
        drive(0, 0, 7, 1, 5, 9);
        check_all("after_rst", 0, 0, 0, 0, 0);
        drive(0, 0, 7, 2, 5, 9);
        drive(0, 0, 7, 1, 5, 9);
        check_all("still_idle", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_event_gen.md
Name: score_event_gen

Overview:
- Producer side of the score digit chain. Watches the pipe position and the bird position from the game field.
- Emits exactly one single-cycle increment pulse each time the bird clears a pipe. The pulse drives the counter2 input of the least-significant scoreboard digit.
- Detects collisions and a maximum-score win, and freezes scoring in either case.
- Sits between the field/pipe logic and the three-digit scoreboard chain on the DE1-SoC.

Parameters:
- ROWS, 16: number of field rows; row 0 is the top, row ROWS-1 is the ground.
- COLS, 16: number of field columns.
- BIRD_COL, 2: fixed column occupied by the bird.
- MAX_SCORE, 999: pass count at which the game is won; the chain displays 3 decimal digits.

Ports:
- Clock, input, 1: system clock, posedge.
- RST, input, 1: synchronous, active-high reset.
- start, input, 1: level; begins a game when in IDLE.
- bird_row, input, $clog2(ROWS): current bird row.
- pipe_col, input, $clog2(COLS): column of the active pipe.
- gap_top, input, $clog2(ROWS): first open row of the gap (inclusive).
- gap_bot, input, $clog2(ROWS): last open row of the gap (inclusive).
- score_inc, output, 1: one-cycle pulse per pipe cleared; connects to digit-0 counter2.
- game_over, output, 1: sticky collision flag.
- win, output, 1: sticky MAX_SCORE-reached flag.
- running, output, 1: high in ARMED or IN_PIPE.
- pass_count, output, 10: binary count of pipes cleared; for verification and debug.

Behaviour:
- Reset: synchronous, active-high on RST.
  - State goes to IDLE; score_inc=0, game_over=0, win=0, running=0, pass_count=0.
  - Reset takes priority over every other event, including during a pulse cycle.
- All outputs are registered. Detection-to-output latency is exactly 1 cycle.
- safe = (gap_top <= gap_bot) && (gap_top <= bird_row <= gap_bot) && (bird_row != ROWS-1).
  - gap_top > gap_bot means no gap: safe=0.
- States:
  - IDLE: running=0. If start=1, go to ARMED next cycle. No pass is counted for a pipe already at BIRD_COL at start; it must first be seen in IN_PIPE.
  - ARMED:
    - If bird_row == ROWS-1, go to GAMEOVER.
    - Else if pipe_col == BIRD_COL: go to IN_PIPE if safe, otherwise GAMEOVER.
    - Else stay in ARMED.
  - IN_PIPE:
    - If pipe_col == BIRD_COL and !safe, go to GAMEOVER. Collision has priority.
    - Else if pipe_col != BIRD_COL, the pipe has left: this is a pass.
      - score_inc=1 on the next cycle only.
      - pass_count increments.
      - Go to WIN if the new count == MAX_SCORE, else ARMED.
    - Else stay in IN_PIPE.
  - GAMEOVER: game_over=1, running=0, no pulses. Leaves only on RST.
  - WIN: win=1, running=0, no pulses. Leaves only on RST.
- score_inc is never high for two consecutive cycles.
  - A pipe re-entering BIRD_COL requires ARMED -> IN_PIPE before it can be counted again.
- Simultaneous events:
  - Pipe leaves while the bird is out of the gap: counts as a pass. Safety is evaluated only while pipe_col == BIRD_COL.
  - Ground hit while in IN_PIPE with pipe_col == BIRD_COL: !safe, so GAMEOVER.
- start is ignored outside IDLE.
- pass_count saturates at MAX_SCORE. It never wraps.

Decomposition:
- Shared package flappy_pkg holds:
  - Enum state_t {IDLE, ARMED, IN_PIPE, GAMEOVER, WIN}.
  - Localparams for ROW_W and COL_W widths.
  - Default values for ROWS, COLS and BIRD_COL, shared with the field and pipe blocks.
- Sub-module gap_check: purely combinational safe computation (bird_row, gap_top, gap_bot -> safe).
- FSM, output registers and counter live in score_event_gen.

Test Plan:
- RST=1 for 2 cycles, then 0 with start=0 -> state IDLE; all outputs 0; running=0 indefinitely.
- start=1 for 1 cycle; gap 5..9, bird_row=7; pipe_col steps 4,3,2,2,1 one per cycle -> exactly one score_inc pulse, 1 cycle after pipe_col becomes 1; pass_count=1; running=1.
- gap 5..9, bird_row=3 when pipe_col reaches 2 -> game_over=1 one cycle later; score_inc stays 0; later pipes produce no pulses until RST.
- Bird safe on entry, bird_row moves to 12 while pipe_col still 2 -> GAMEOVER, no pulse. Repeat with bird_row=12 in the same cycle pipe_col goes 2->1 -> pulse, no game_over.
- Preload MAX_SCORE=3 and clear 3 pipes -> 3 pulses, win=1 after the third; a fourth pipe produces no pulse; pass_count=3.
- Assert RST in the same cycle a pass is detected -> no pulse; all outputs 0 next cycle; state IDLE.
- gap_top=9, gap_bot=5 with pipe at BIRD_COL -> GAMEOVER regardless of bird_row.
